// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM states,
// framing constants and counter widths.
package loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_SUM
  } state_e;

  localparam logic [7:0] HDR_BYTE    = 8'hA5;
  localparam int         MAX_WORDS   = 64;
  localparam int         AW_DEF      = 6;
  localparam int         REM_W       = 7;
  localparam int         BYTE_W      = 2;
  localparam int         TIMEOUT_DEF = 1_000_000;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: reloads on clear or while disabled, and strobes
// expire once TIMEOUT consecutive enabled cycles pass without a clear.
module loader_timeout
  import loader_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The load value is TIMEOUT-1 so that the cycle holding zero is the
  // TIMEOUT-th idle cycle after the last clear.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clr || !en) begin
      cnt_d = LOAD;
    end else if (cnt_q == '0) begin
      expire = 1'b1;
      cnt_d  = LOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Framed UART program loader: packs big-endian words into instruction
// memory and holds the CPU in reset until the frame checksum verifies.
module inst_loader
  import loader_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [23:0]         shift_q, shift_d;
  logic [7:0]          csum_q, csum_d;
  logic                im_we_q, im_we_d;
  logic [AW-1:0]       im_addr_q, im_addr_d;
  logic [31:0]         im_wdata_q, im_wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                to_expire;

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q != S_IDLE),
    .clr    (rx_valid),
    .expire (to_expire)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cpu_rst_d  = cpu_rst_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == HDR_BYTE) begin
          state_d    = S_LEN;
          cpu_rst_d  = 1'b1;
          err_d      = 1'b0;
          addr_d     = '0;
          csum_d     = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          rem_d   = (rx_data == 8'h00) ? REM_W'(MAX_WORDS) : rx_data[REM_W-1:0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Only the upper three bytes are kept; the fourth goes straight into the write word.
        if (rx_valid) begin
          csum_d     = csum_q ^ rx_data;
          shift_d    = {shift_q[15:0], rx_data};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BYTE_W'(3)) begin
            im_we_d    = 1'b1;
            im_addr_d  = addr_q;
            im_wdata_d = {shift_q, rx_data};
            addr_d     = addr_q + 1'b1;
            rem_d      = rem_q - 1'b1;
            if (rem_q == REM_W'(1)) begin
              state_d = S_SUM;
            end
          end
        end
      end
      S_SUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (to_expire) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_rst  = cpu_rst_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: frames are replayed from a byte queue and
// memory writes / done pulses are logged by a monitor for later checking.
module tb_inst_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  int            tests_run = 0;
  int            tests_failed = 0;
  logic [7:0]    stim_q[$];
  logic [31:0]   log_addr[$];
  logic [31:0]   log_data[$];
  int            done_cnt = 0;
  int            wr_base;
  int            done_base;

  inst_loader #(
    .TIMEOUT (16),
    .AW      (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Outputs settle at posedge, so logging on negedge sees each pulse once.
  always @(negedge clk) begin
    if (im_we) begin
      log_addr.push_back(32'(im_addr));
      log_data.push_back(im_wdata);
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run = tests_run + 1;
    if (actual !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Replays stim_q; without back-to-back an idle cycle separates bytes.
  task automatic applyStimulus(input bit b2b);
    for (int i = 0; i < stim_q.size(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = stim_q[i];
      if (!b2b && i != stim_q.size() - 1) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    stim_q.delete();
  endtask

  function automatic logic [31:0] logAddr(input int i);
    return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] logData(input int i);
    return (i < log_data.size()) ? log_data[i] : 32'hDEAD_0000;
  endfunction

  task automatic markLog();
    wr_base   = log_addr.size();
    done_base = done_cnt;
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("reset im_we", 32'(im_we), 32'd0);
    checkOutput("reset im_addr", 32'(im_addr), 32'd0);
    checkOutput("reset im_wdata", im_wdata, 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Garbage in idle is ignored
    markLog();
    stim_q = '{8'h00, 8'hFF};
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("garbage busy", 32'(busy), 32'd0);
    checkOutput("garbage cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("garbage writes", 32'(log_addr.size() - wr_base), 32'd0);

    // Single word frame
    markLog();
    stim_q = '{8'hA5, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("single writes", 32'(log_addr.size() - wr_base), 32'd1);
    checkOutput("single addr", logAddr(wr_base), 32'd0);
    checkOutput("single data", logData(wr_base), 32'h20080005);
    checkOutput("single done", 32'(done_cnt - done_base), 32'd1);
    checkOutput("single cpu_rst", 32'(cpu_rst), 32'd0);
    checkOutput("single err", 32'(err), 32'd0);
    checkOutput("single busy", 32'(busy), 32'd0);

    // Three words, back-to-back; the header must reassert cpu_rst
    markLog();
    stim_q = '{8'hA5, 8'h03};
    applyStimulus(1'b0);
    checkOutput("reload cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("reload busy", 32'(busy), 32'd1);
    stim_q = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
               8'h33, 8'h33, 8'h33, 8'h33, 8'h00};
    applyStimulus(1'b1);
    repeat (2) @(negedge clk);
    checkOutput("b2b writes", 32'(log_addr.size() - wr_base), 32'd3);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("b2b addr%0d", k), logAddr(wr_base + k), 32'(k));
      checkOutput($sformatf("b2b data%0d", k), logData(wr_base + k), {4{8'(8'h11 * (k + 1))}});
    end
    checkOutput("b2b done", 32'(done_cnt - done_base), 32'd1);
    checkOutput("b2b cpu_rst", 32'(cpu_rst), 32'd0);

    // Count 0 means 64 words; bytes 0..255 XOR to 00 and include A5 as data
    markLog();
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'h00);
    for (int j = 0; j < 256; j++) stim_q.push_back(8'(j));
    stim_q.push_back(8'h00);
    applyStimulus(1'b1);
    repeat (2) @(negedge clk);
    checkOutput("full writes", 32'(log_addr.size() - wr_base), 32'd64);
    for (int k = 0; k < 64; k++) begin
      checkOutput($sformatf("full addr%0d", k), logAddr(wr_base + k), 32'(k));
      checkOutput($sformatf("full data%0d", k), logData(wr_base + k),
                  {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
    end
    checkOutput("full final im_addr", 32'(im_addr), 32'd63);
    checkOutput("full done", 32'(done_cnt - done_base), 32'd1);
    checkOutput("full cpu_rst", 32'(cpu_rst), 32'd0);

    // Bad checksum: word written, error latched, CPU kept in reset
    markLog();
    stim_q = '{8'hA5, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hFF};
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("badsum writes", 32'(log_addr.size() - wr_base), 32'd1);
    checkOutput("badsum data", logData(wr_base), 32'h20080005);
    checkOutput("badsum err", 32'(err), 32'd1);
    checkOutput("badsum cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("badsum done", 32'(done_cnt - done_base), 32'd0);
    checkOutput("badsum busy", 32'(busy), 32'd0);

    markLog();
    stim_q = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("recover data", logData(wr_base), 32'hDEADBEEF);
    checkOutput("recover addr", logAddr(wr_base), 32'd0);
    checkOutput("recover err", 32'(err), 32'd0);
    checkOutput("recover cpu_rst", 32'(cpu_rst), 32'd0);
    checkOutput("recover done", 32'(done_cnt - done_base), 32'd1);

    // Timeout: 16 idle cycles after the last byte
    markLog();
    stim_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
    applyStimulus(1'b0);
    checkOutput("timeout busy early", 32'(busy), 32'd1);
    repeat (15) @(negedge clk);
    checkOutput("timeout err at 15", 32'(err), 32'd0);
    checkOutput("timeout busy at 15", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("timeout err at 16", 32'(err), 32'd1);
    checkOutput("timeout busy at 16", 32'(busy), 32'd0);
    checkOutput("timeout cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("timeout writes", 32'(log_addr.size() - wr_base), 32'd0);

    // Asynchronous reset in the middle of the data phase
    stim_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    applyStimulus(1'b0);
    checkOutput("pre-rst busy", 32'(busy), 32'd1);
    checkOutput("pre-rst wdata", im_wdata, 32'h11223344);
    #2 rst = 1'b1;
    #1;
    checkOutput("async cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("async busy", 32'(busy), 32'd0);
    checkOutput("async im_we", 32'(im_we), 32'd0);
    checkOutput("async im_addr", 32'(im_addr), 32'd0);
    checkOutput("async im_wdata", im_wdata, 32'd0);
    checkOutput("async done", 32'(done), 32'd0);
    checkOutput("async err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader sitting directly upstream of the single-cycle RIJ CPU's instruction memory. It receives a framed byte stream from a UART receiver, packs bytes into big-endian 32-bit words, and writes them to the 64-word instruction memory through its write port. It holds the CPU in reset until a complete frame with a matching checksum has been loaded. Frame format, in order:
- header 8'hA5
- word count N (0 means 64)
- 4·N data bytes
- XOR checksum byte

## Interface
- TIMEOUT, 1_000_000: idle clock cycles allowed between bytes inside a frame before abort.
- AW, 6: instruction-memory word-address width; matches PC[7:2].
- clk  input  1  system clock; same domain as the instruction-memory write port.
- rst  input  1  reset, asynchronous, active-high.
- rx_valid  input  1  one-cycle strobe; rx_data is valid.
- rx_data  input  8  received byte.
- im_we  output  1  instruction-memory write enable, one-cycle pulse.
- im_addr  output  AW  word address for the write.
- im_wdata  output  32  word to write.
- cpu_rst  output  1  reset to the CPU, active-high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when a frame is loaded and verified.
- err  output  1  sticky error flag.

## Operation
- States: S_IDLE, S_LEN, S_DATA, S_SUM.
- S_IDLE:
  - byte 8'hA5 → S_LEN; cpu_rst←1, err←0, word address←0, checksum←0.
  - Any other byte is ignored.
- S_LEN:
  - Any byte is taken as N; remaining←(N==0 ? 64 : N) (7-bit).
  - Next state is S_DATA.
- S_DATA:
  - Bytes are shifted in MSB-first: byte 0 → [31:24], byte 3 → [7:0].
  - Every data byte is XORed into the checksum.
  - On the 4th byte: im_we is issued, word address increments (wraps mod 64), remaining decrements.
  - When remaining reaches 0 → S_SUM.
- S_SUM:
  - Received byte == checksum: done pulse, cpu_rst←0, → S_IDLE.
  - Mismatch: err←1, cpu_rst stays 1, → S_IDLE.
- Timeout: in S_LEN, S_DATA or S_SUM, if TIMEOUT cycles pass with no rx_valid → err←1, cpu_rst stays 1, → S_IDLE.
- Partially written words are not rolled back.
- A header byte arriving while the CPU is running (S_IDLE, cpu_rst=0) starts a reload and reasserts cpu_rst.
- Inside a frame, 8'hA5 is ordinary data. There is no resync.
- busy = (state != S_IDLE).

## Timing
- Reset values: state S_IDLE; cpu_rst=1; im_we=0; im_addr=0; im_wdata=0; busy=0; done=0; err=0; all internal counters and checksum 0.
- rx_data is sampled on the rising edge where rx_valid=1. State changes are visible the next cycle.
- im_we is registered. It is high for exactly one cycle, the cycle after the 4th byte of a word is accepted, with im_addr and im_wdata stable in that cycle.
- Back-to-back rx_valid on every cycle must be supported: the write of word k overlaps acceptance of byte 0 of word k+1 with no loss.
- done and cpu_rst deassertion take effect in the cycle after the checksum byte is accepted.
- The timeout counter resets on every accepted byte. Abort happens on the cycle the counter reaches TIMEOUT.
- Asserting rst mid-frame aborts immediately to reset values. cpu_rst=1 holds the CPU in reset.

## Structure
- Shared package loader_pkg holds:
  - the state enum
  - HDR_BYTE = 8'hA5
  - MAX_WORDS = 64
  - the counter width constants
- One sub-module, loader_timeout: a TIMEOUT-cycle down-counter with a clear input and an expire strobe.
- Everything else, the FSM and the byte packer, lives in inst_loader.

## Test plan
- Single word:
  - Stimulus: A5, 01, 20, 08, 00, 05, checksum 2D.
  - Required: one im_we with addr 0, wdata 32'h20080005; then done pulse, cpu_rst 1→0, err=0.
- Three words, back-to-back rx_valid:
  - Stimulus: words 32'h11111111, 32'h22222222, 32'h33333333, checksum 00.
  - Required: writes to addr 0, 1, 2, no bytes lost; done.
- Count 0 with 256 data bytes:
  - Required: 64 writes, addr 0..63; final addr 63; done.
- Bad checksum:
  - Stimulus: single-word frame with checksum FF.
  - Required: word still written; err=1, cpu_rst stays 1, no done; a subsequent good frame clears err and releases cpu_rst.
- Timeout:
  - Stimulus: with TIMEOUT=16, send A5, 02, 3 bytes, then stall.
  - Required: err=1 exactly 16 cycles after the last byte; state S_IDLE; busy=0.
- Garbage and reset:
  - Stimulus: bytes 00, FF in S_IDLE.
  - Required: ignored; no state change.
  - Stimulus: rst asserted mid-S_DATA.
  - Required: all outputs return to their reset values asynchronously.
